plru_alloc_ctrl: RTL and testbench

Allocation controller for a 2**LG2_DEPTH-entry fully associative buffer, using tree pseudo-LRU replacement. It accepts allocation requests and picks a slot: the lowest-index free slot first, otherwise the PLRU victim. Before granting an occupied slot it sequences an eviction handshake with the downstream writeback path. Hit traffic updates the PLRU state through a touch port, and individual slots can be freed through an invalidate port.

---
 rtl/plru_pkg.sv | 50 +++++
 rtl/plru_alloc_ctrl_if.sv | 34 +++
 rtl/plru_tree_state.sv | 44 ++++
 rtl/plru_alloc_ctrl.sv | 114 +++++++++++
 tb/tb_plru_alloc_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/plru_pkg.sv
// Shared types and tree pseudo-LRU helpers for the allocation controller.
// Trees are carried in a max-size vector (bit n = node n, bit 0 unused) so one function serves any depth up to 64 entries.
package plru_pkg;

  localparam int PLRU_MAX_LG2 = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVICT,
    ST_GRANT
  } alloc_state_e;

  typedef logic [(1 << PLRU_MAX_LG2)-1:0] plru_tree_t;
  typedef logic [PLRU_MAX_LG2-1:0]        plru_idx_t;

  // Follow node bits from the root; each bit read is also the next index bit.
  function automatic plru_idx_t plru_victim(plru_tree_t tree, int lg2);
    plru_idx_t node;
    plru_idx_t idx;
    node = plru_idx_t'(1);
    idx  = '0;
    for (int l = 0; l < PLRU_MAX_LG2; l++) begin
      if (l < lg2) begin
        idx  = {idx[PLRU_MAX_LG2-2:0], tree[node]};
        node = {node[PLRU_MAX_LG2-2:0], tree[node]};
      end
    end
    return idx;
  endfunction

  function automatic plru_tree_t plru_update(plru_tree_t tree, plru_idx_t idx, int lg2);
    plru_tree_t t;
    plru_idx_t  node;
    plru_idx_t  path;
    logic       dir;
    t    = tree;
    node = plru_idx_t'(1);
    path = idx << (PLRU_MAX_LG2 - lg2);
    for (int l = 0; l < PLRU_MAX_LG2; l++) begin
      if (l < lg2) begin
        dir     = path[PLRU_MAX_LG2-1];
        t[node] = ~dir;
        node    = {node[PLRU_MAX_LG2-2:0], dir};
        path    = path << 1;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/plru_alloc_ctrl_if.sv
// Request/touch/invalidate/eviction signal bundle for plru_alloc_ctrl.
// master = requesting/downstream side, slave = the controller.
interface plru_alloc_ctrl_if #(
  parameter int LG2_DEPTH = 3,
  parameter int DW        = 32
);
  localparam int N = 1 << LG2_DEPTH;

  logic                 alloc_req;
  logic [DW-1:0]        alloc_tag;
  logic                 alloc_gnt;
  logic [LG2_DEPTH-1:0] alloc_idx;
  logic                 touch_valid;
  logic [LG2_DEPTH-1:0] touch_idx;
  logic                 inval_valid;
  logic [LG2_DEPTH-1:0] inval_idx;
  logic                 evict_valid;
  logic [LG2_DEPTH-1:0] evict_idx;
  logic [DW-1:0]        evict_tag;
  logic                 evict_ready;
  logic [N-1:0]         valid_mask;
  logic                 full;

  modport master (
    output alloc_req, alloc_tag, touch_valid, touch_idx, inval_valid, inval_idx, evict_ready,
    input  alloc_gnt, alloc_idx, evict_valid, evict_idx, evict_tag, valid_mask, full
  );

  modport slave (
    input  alloc_req, alloc_tag, touch_valid, touch_idx, inval_valid, inval_idx, evict_ready,
    output alloc_gnt, alloc_idx, evict_valid, evict_idx, evict_tag, valid_mask, full
  );

endinterface

// File: rtl/plru_tree_state.sv
// PLRU node flops (nodes 1..N-1) with a single update port and a
// combinational victim output.
module plru_tree_state
  import plru_pkg::*;
#(
  parameter int LG2_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 upd_valid,
  input  logic [LG2_DEPTH-1:0] upd_idx,
  output logic [LG2_DEPTH-1:0] victim_idx
);

  localparam int N = 1 << LG2_DEPTH;

  logic [N-1:1] tree_q, tree_d;
  plru_tree_t   tree_ext, tree_new;
  plru_idx_t    idx_ext, victim_ext;
  logic         unused_ext_bits;

  // NOTE: every output gets a default at the top of the block so no path
  // leaves it unassigned; that is what keeps this logic latch-free.
  always_comb begin
    tree_ext          = '0;
    tree_ext[N-1:1]   = tree_q;
    idx_ext           = '0;
    idx_ext[LG2_DEPTH-1:0] = upd_idx;
    tree_new          = plru_update(tree_ext, idx_ext, LG2_DEPTH);
    victim_ext        = plru_victim(tree_ext, LG2_DEPTH);
    tree_d            = upd_valid ? tree_new[N-1:1] : tree_q;
    victim_idx        = victim_ext[LG2_DEPTH-1:0];
  end

  assign unused_ext_bits = ^{tree_new, victim_ext};

  // NOTE: flops take non-blocking (<=) so all registers update together at
  // the edge; combinational blocks use blocking (=) to allow overrides.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tree_q <= '0;
    else         tree_q <= tree_d;
  end

endmodule

// File: rtl/plru_alloc_ctrl.sv
// Allocation controller: lowest free slot first, otherwise PLRU victim with
// an eviction handshake before the grant.
module plru_alloc_ctrl
  import plru_pkg::*;
#(
  parameter int LG2_DEPTH = 3,
  parameter int DW        = 32
) (
  input logic             clk,
  input logic             resetn,
  plru_alloc_ctrl_if.slave bus
);

  localparam int N = 1 << LG2_DEPTH;
  typedef logic [LG2_DEPTH-1:0] idx_t;

  alloc_state_e  state_q, state_d;
  idx_t          sel_q, sel_d;
  logic [N-1:0]  valid_q, valid_d;
  logic [DW-1:0] tag_q [N];
  logic          tag_we;
  logic          upd_valid;
  idx_t          upd_idx;
  idx_t          victim_idx;
  idx_t          free_idx;
  logic          any_free;
  logic          touch_ok;

  plru_tree_state #(.LG2_DEPTH(LG2_DEPTH)) u_tree (
    .clk        (clk),
    .resetn     (resetn),
    .upd_valid  (upd_valid),
    .upd_idx    (upd_idx),
    .victim_idx (victim_idx)
  );

  // Descending scan so the last hit written is the lowest free index.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx = idx_t'(i);
        any_free = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    tag_we    = 1'b0;
    upd_valid = 1'b0;
    upd_idx   = bus.touch_idx;
    touch_ok  = bus.touch_valid && valid_q[bus.touch_idx];

    // The slot owned by an eviction or grant in flight cannot be freed under it.
    if (bus.inval_valid && !(state_q != ST_IDLE && bus.inval_idx == sel_q))
      valid_d[bus.inval_idx] = 1'b0;

    case (state_q)
      ST_IDLE: begin
        upd_valid = touch_ok;
        if (bus.alloc_req) begin
          state_d = any_free ? ST_GRANT : ST_EVICT;
          sel_d   = any_free ? free_idx : victim_idx;
        end
      end
      ST_EVICT: begin
        upd_valid = touch_ok;
        if (bus.evict_ready) begin
          valid_d[sel_q] = 1'b0;
          state_d        = ST_GRANT;
        end
      end
      ST_GRANT: begin
        valid_d[sel_q] = 1'b1;
        tag_we         = 1'b1;
        upd_valid      = 1'b1;
        upd_idx        = sel_q;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: the tag array has no reset; a tag is only observed through a
  // valid slot, and the evict_tag output is gated to zero outside EVICT.
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[sel_q] <= bus.alloc_tag;
  end

  assign bus.alloc_gnt   = (state_q == ST_GRANT);
  assign bus.alloc_idx   = bus.alloc_gnt ? sel_q : '0;
  assign bus.evict_valid = (state_q == ST_EVICT);
  assign bus.evict_idx   = bus.evict_valid ? sel_q : '0;
  assign bus.evict_tag   = bus.evict_valid ? tag_q[sel_q] : '0;
  assign bus.valid_mask  = valid_q;
  assign bus.full        = &valid_q;

endmodule

// File: tb/tb_plru_alloc_ctrl.sv
// Bench for plru_alloc_ctrl (LG2_DEPTH=3): directed vector table, collision
// sequences and a random phase predicted by a heap-indexed PLRU model.
module tb_plru_alloc_ctrl;

  localparam int LG2 = 3;
  localparam int N   = 8;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  plru_alloc_ctrl_if #(.LG2_DEPTH(LG2), .DW(32)) bus ();

  plru_alloc_ctrl #(.LG2_DEPTH(LG2), .DW(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  int          m_tree  [N];   // heap nodes 1..7; leaf of slot i is node 8+i

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tree[i]  = 0;
    end
  endfunction

  function automatic int m_victim();
    int n;
    n = 1;
    for (int k = 0; k < LG2; k++) n = 2 * n + m_tree[n];
    return n - N;
  endfunction

  // Each ancestor of the leaf points to the sibling of the child on the path.
  function automatic void m_touch(int i);
    int leaf;
    int child;
    leaf = N + i;
    for (int k = 1; k <= LG2; k++) begin
      child = leaf >> (k - 1);
      m_tree[leaf >> k] = (child % 2 == 0) ? 1 : 0;
    end
  endfunction

  function automatic int m_lowest_free();
    for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] m_mask();
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[i] = m_valid[i];
    return m;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_mask(input logic [7:0] exp_mask);
    check("valid_mask", 64'(bus.valid_mask), 64'(exp_mask));
    check("full", 64'(bus.full), 64'(exp_mask == 8'hFF));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"},   64'(bus.alloc_gnt),   64'd0);
    check({tag, "_aidx"},  64'(bus.alloc_idx),   64'd0);
    check({tag, "_ev"},    64'(bus.evict_valid), 64'd0);
    check({tag, "_eidx"},  64'(bus.evict_idx),   64'd0);
    check({tag, "_etag"},  64'(bus.evict_tag),   64'd0);
    check({tag, "_mask"},  64'(bus.valid_mask),  64'd0);
    check({tag, "_full"},  64'(bus.full),        64'd0);
  endtask

  task automatic do_touch(input int i);
    bus.touch_valid = 1'b1;
    bus.touch_idx   = 3'(i);
    @(posedge clk); #1;
    bus.touch_valid = 1'b0;
    if (m_valid[i]) m_touch(i);
  endtask

  task automatic do_inval(input int i);
    bus.inval_valid = 1'b1;
    bus.inval_idx   = 3'(i);
    @(posedge clk); #1;
    bus.inval_valid = 1'b0;
    m_valid[i] = 1'b0;
  endtask

  // Full allocation transaction. Optional collisions: a touch driven into the
  // GRANT cycle, an inval of the granted slot in GRANT, an inval of the
  // victim during EVICT. Returns one cycle after the grant, with the DUT idle.
  task automatic do_alloc(input logic [31:0] tag, input int delay,
                          input bit exp_evict, input int exp_eidx,
                          input logic [31:0] exp_etag, input int exp_gidx,
                          input int gnt_touch, input bit gnt_inval,
                          input bit evict_inval);
    int c;
    int stall;
    bit seen_ev;
    bit done;
    c = 0; stall = 0; seen_ev = 1'b0; done = 1'b0;
    bus.alloc_req = 1'b1;
    bus.alloc_tag = tag;
    while (!done && c < 20) begin
      @(posedge clk); #1;
      c++;
      bus.inval_valid = 1'b0;
      if (bus.alloc_gnt) begin
        done = 1'b1;
        bus.alloc_req   = 1'b0;
        bus.evict_ready = 1'b0;
        check("gnt_idx",     64'(bus.alloc_idx), 64'(exp_gidx));
        check("gnt_latency", 64'(c), 64'(exp_evict ? 2 + delay : 1));
        check("evicted",     64'(seen_ev), 64'(exp_evict));
        if (gnt_touch >= 0) begin
          bus.touch_valid = 1'b1;
          bus.touch_idx   = 3'(gnt_touch);
        end
        if (gnt_inval) begin
          bus.inval_valid = 1'b1;
          bus.inval_idx   = 3'(exp_gidx);
        end
        @(posedge clk); #1;
        bus.touch_valid = 1'b0;
        bus.inval_valid = 1'b0;
        if (gnt_inval) check("gnt_beats_inval", 64'(bus.valid_mask[exp_gidx]), 64'd1);
      end else if (bus.evict_valid) begin
        seen_ev = 1'b1;
        check("evict_idx", 64'(bus.evict_idx), 64'(exp_eidx));
        check("evict_tag", 64'(bus.evict_tag), 64'(exp_etag));
        if (evict_inval && stall == 1)
          check("victim_inval_ignored", 64'(bus.valid_mask[exp_eidx]), 64'd1);
        if (evict_inval && stall == 0) begin
          bus.inval_valid = 1'b1;
          bus.inval_idx   = 3'(exp_eidx);
        end
        bus.evict_ready = (stall >= delay);
        stall++;
      end
    end
    if (!done) begin
      check("alloc_timeout", 64'd0, 64'd1);
      bus.alloc_req   = 1'b0;
      bus.evict_ready = 1'b0;
      bus.touch_valid = 1'b0;
      bus.inval_valid = 1'b0;
    end
    m_valid[exp_gidx] = 1'b1;
    m_tag[exp_gidx]   = tag;
    m_touch(exp_gidx);
  endtask

  // Allocation whose expectations come from the model.
  task automatic model_alloc(input logic [31:0] tag, input int delay);
    int f;
    int v;
    f = m_lowest_free();
    v = m_victim();
    if (f >= 0) do_alloc(tag, delay, 1'b0, 0, 32'd0, f, -1, 1'b0, 1'b0);
    else        do_alloc(tag, delay, 1'b1, v, m_tag[v], v, -1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    bus.alloc_req = 1'b0; bus.touch_valid = 1'b0;
    bus.inval_valid = 1'b0; bus.evict_ready = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    m_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef enum int {OP_ALLOC, OP_TOUCH, OP_INVAL} op_e;
  typedef struct {
    op_e         op;
    int          idx;
    logic [31:0] tag;
    int          delay;
    bit          exp_evict;
    int          exp_eidx;
    logic [31:0] exp_etag;
    int          exp_gidx;
    logic [7:0]  exp_mask;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int v;
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    bus.alloc_req = 1'b0; bus.alloc_tag = '0;
    bus.touch_valid = 1'b0; bus.touch_idx = '0;
    bus.inval_valid = 1'b0; bus.inval_idx = '0;
    bus.evict_ready = 1'b0;
    m_reset();

    for (int i = 0; i < 8; i++)
      vecs[i] = '{OP_ALLOC, 0, 32'h100 + 32'(i), 0, 1'b0, 0, 32'd0, i, 8'((1 << (i + 1)) - 1)};
    vecs[8]  = '{OP_ALLOC, 0, 32'h200, 3, 1'b1, 0, 32'h100, 0, 8'hFF};
    vecs[9]  = '{OP_TOUCH, 0, 32'd0,   0, 1'b0, 0, 32'd0,   0, 8'hFF};
    vecs[10] = '{OP_ALLOC, 0, 32'h300, 0, 1'b1, 4, 32'h104, 4, 8'hFF};
    vecs[11] = '{OP_INVAL, 5, 32'd0,   0, 1'b0, 0, 32'd0,   0, 8'hDF};
    vecs[12] = '{OP_ALLOC, 0, 32'h400, 0, 1'b0, 0, 32'd0,   5, 8'hFF};

    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      case (vecs[i].op)
        OP_ALLOC: do_alloc(vecs[i].tag, vecs[i].delay, vecs[i].exp_evict, vecs[i].exp_eidx,
                           vecs[i].exp_etag, vecs[i].exp_gidx, -1, 1'b0, 1'b0);
        OP_TOUCH: do_touch(vecs[i].idx);
        default:  do_inval(vecs[i].idx);
      endcase
      check_mask(vecs[i].exp_mask);
    end

    // Reset while an eviction is being offered.
    v = m_victim();
    bus.alloc_req = 1'b1;
    bus.alloc_tag = 32'h500;
    @(posedge clk); #1;
    check("pre_reset_evict_valid", 64'(bus.evict_valid), 64'd1);
    check("pre_reset_evict_idx",   64'(bus.evict_idx),   64'(v));
    bus.alloc_req = 1'b0;
    resetn = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(posedge clk); #1;
    resetn = 1'b1;
    m_reset();
    @(posedge clk); #1;
    check_idle_outputs("postrst");
    do_alloc(32'h501, 0, 1'b0, 0, 32'd0, 0, -1, 1'b0, 1'b0);
    check_mask(8'h01);

    // Touch in GRANT is dropped: victim after a clean fill stays slot 0.
    do_reset();
    for (int i = 0; i < 7; i++) do_alloc(32'h600 + 32'(i), 0, 1'b0, 0, 32'd0, i, -1, 1'b0, 1'b0);
    do_alloc(32'h607, 0, 1'b0, 0, 32'd0, 7, 0, 1'b0, 1'b0);
    check_mask(8'hFF);
    do_alloc(32'h610, 1, 1'b1, 0, 32'h600, 0, -1, 1'b0, 1'b0);
    // Inval on the victim during EVICT: handshake still needed.
    do_alloc(32'h611, 2, 1'b1, 4, 32'h604, 4, -1, 1'b0, 1'b1);
    check_mask(8'hFF);
    // Inval on the granted slot during GRANT: slot ends valid.
    do_alloc(32'h612, 0, 1'b1, 2, 32'h602, 2, -1, 1'b1, 1'b0);
    check_mask(8'hFF);

    // Random phase against the model.
    for (int n = 0; n < 120; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 3)      do_touch(int'($urandom_range(0, 7)));
      else if (r < 5) do_inval(int'($urandom_range(0, 7)));
      else            model_alloc($urandom, int'($urandom_range(0, 3)));
      check_mask(m_mask());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
